// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_controller_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

endpackage

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - launch/wait/complete sequencing for the multi-cycle execute unit
module mc_sequencer
    import hazard_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic multi_cycle,
    input  logic pc_src,
    input  logic mc_done,
    output logic mc_stall,
    output logic hazard_en,
    output logic mc_start,
    output logic mc_timeout
);

    localparam int CW = $clog2(MC_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

    mc_state_t     state;
    logic [CW-1:0] cnt;
    logic          launch;
    logic          expire;

    // A taken branch kills the instruction in E, so it must not launch the unit.
    assign launch = (state == MC_IDLE) && multi_cycle && !pc_src;
    assign expire = (state == MC_BUSY) && (cnt == CNT_LAST);

    // The launch cycle already freezes the front end so the instruction stays in E.
    assign mc_stall  = launch || (state == MC_BUSY);
    assign hazard_en = (state == MC_IDLE) || (state == MC_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MC_IDLE;
            cnt        <= '0;
            mc_start   <= 1'b0;
            mc_timeout <= 1'b0;
        end else begin
            mc_start <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (launch) begin
                        state    <= MC_BUSY;
                        cnt      <= '0;
                        mc_start <= 1'b1;
                    end
                end
                MC_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (expire) begin
                        mc_timeout <= 1'b1;
                    end
                    if (mc_done || expire) begin
                        state <= MC_DONE;
                    end
                end
                MC_DONE: begin
                    state <= MC_IDLE;
                end
                default: begin
                    state <= MC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use stall, branch flush and multi-cycle freeze control
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic [1:0]        ResultSrc_E,
    input  logic              PCSrc_E,
    input  logic              MultiCycle_E,
    input  logic              MC_Done,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Bubble_M,
    output logic              MC_Start,
    output logic              MC_Timeout
);

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mc_stall;
    logic       hazard_en;
    logic       mc_start_q;
    logic       mc_timeout_q;
    logic       load_use;
    logic       branch;

    mc_sequencer #(
        .MC_TIMEOUT(MC_TIMEOUT)
    ) u_mc_sequencer (
        .clk        (clk),
        .rst        (rst),
        .multi_cycle(MultiCycle_E),
        .pc_src     (PCSrc_E),
        .mc_done    (MC_Done),
        .mc_stall   (mc_stall),
        .hazard_en  (hazard_en),
        .mc_start   (mc_start_q),
        .mc_timeout (mc_timeout_q)
    );

    // The memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        fwd_a = FWD_RF;
        if (RegWrite_M && (RD_M != '0) && (RD_M == Rs1_E)) begin
            fwd_a = FWD_M;
        end else if (RegWrite_W && (RD_W != '0) && (RD_W == Rs1_E)) begin
            fwd_a = FWD_W;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (RegWrite_M && (RD_M != '0) && (RD_M == Rs2_E)) begin
            fwd_b = FWD_M;
        end else if (RegWrite_W && (RD_W != '0) && (RD_W == Rs2_E)) begin
            fwd_b = FWD_W;
        end
    end

    assign load_use = hazard_en && (ResultSrc_E == RESULT_LOAD) && (RD_E != '0) &&
                      ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    // While E is frozen for the multi-cycle unit it must never be cleared as well.
    assign branch = PCSrc_E && !mc_stall;

    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Bubble_M   = 1'b0;
        MC_Start   = 1'b0;
        MC_Timeout = 1'b0;
        if (!rst) begin
            ForwardA_E = fwd_a;
            ForwardB_E = fwd_b;
            Stall_F    = mc_stall || (load_use && !branch);
            Stall_D    = mc_stall || (load_use && !branch);
            Stall_E    = mc_stall;
            Flush_D    = branch;
            Flush_E    = branch || (load_use && !mc_stall);
            Bubble_M   = mc_stall;
            MC_Start   = mc_start_q;
            MC_Timeout = mc_timeout_q;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rw_m, rw_w, pcs, mce, mcd;
    logic [1:0] rsrc;
    logic [1:0] fa, fb;
    logic       sf, sd, se, fd, fe, bm, ms, mt;

    int total = 0;
    int bad   = 0;
    logic sticky_to;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rs;
        logic       pc;
        logic [1:0] xfa, xfb;
        logic       xsf, xfd, xfe;
    } vec_t;

    vec_t tv[10];

    always #5 clk = ~clk;

    hazard_controller #(.MC_TIMEOUT(TO), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w),
        .RegWrite_M(rw_m), .RegWrite_W(rw_w), .ResultSrc_E(rsrc),
        .PCSrc_E(pcs), .MultiCycle_E(mce), .MC_Done(mcd),
        .ForwardA_E(fa), .ForwardB_E(fb),
        .Stall_F(sf), .Stall_D(sd), .Stall_E(se),
        .Flush_D(fd), .Flush_E(fe), .Bubble_M(bm),
        .MC_Start(ms), .MC_Timeout(mt)
    );

    function automatic logic [11:0] pk(logic [1:0] a, logic [1:0] b, logic f, logic d, logic e,
                                       logic xd, logic xe, logic m, logic s, logic t);
        return {a, b, f, d, e, xd, xe, m, s, t};
    endfunction

    function automatic vec_t mkv(int r1d, int r2d, int r1e, int r2e, int rde, int rdm, int rdw,
                                 int rwm, int rww, int rs, int pc, int xa, int xb, int xs,
                                 int xd, int xe);
        vec_t v;
        v.rs1d = 5'(r1d); v.rs2d = 5'(r2d); v.rs1e = 5'(r1e); v.rs2e = 5'(r2e);
        v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
        v.rwm = 1'(rwm); v.rww = 1'(rww); v.rs = 2'(rs); v.pc = 1'(pc);
        v.xfa = 2'(xa); v.xfb = 2'(xb); v.xsf = 1'(xs); v.xfd = 1'(xd); v.xfe = 1'(xe);
        return v;
    endfunction

    task automatic chk(string name, logic [11:0] exp);
        logic [11:0] act;
        act = {fa, fb, sf, sd, se, fd, fe, bm, ms, mt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (fa fb sf sd se fd fe bm ms mt)", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        rw_m = 0; rw_w = 0; rsrc = 0; pcs = 0; mce = 0; mcd = 0;
    endtask

    // Plain-arithmetic reference for the combinational rules while no multi-cycle op is active.
    function automatic logic [1:0] fwd_ref(logic [4:0] src, logic wm, logic [4:0] dm,
                                           logic ww, logic [4:0] dw);
        if (wm && dm != 0 && dm == src) return 2'd2;
        if (ww && dw != 0 && dw == src) return 2'd1;
        return 2'd0;
    endfunction

    // One launch: done arrives d cycles after MC_Start (d >= TO means never).
    task automatic run_mc(int d, string tag);
        int  busy_len;
        logic hit_to;
        busy_len = (d < TO - 1) ? d + 1 : TO;
        hit_to   = (d >= TO - 1);
        @(negedge clk); clear_inputs(); mce = 1; mcd = 1; #1;
        chk({tag, "_launch"}, pk(0, 0, 1, 1, 1, 0, 0, 1, 0, sticky_to));
        for (int k = 0; k < busy_len; k++) begin
            @(negedge clk); clear_inputs(); mce = 1;
            mcd = (k == d);
            rsrc = 2'b01; rd_e = 7; rs1_d = 7;
            #1;
            chk($sformatf("%s_busy%0d", tag, k), pk(0, 0, 1, 1, 1, 0, 0, 1, k == 0, sticky_to));
        end
        sticky_to = sticky_to | hit_to;
        @(negedge clk); clear_inputs(); mce = 1; mcd = 1; #1;
        chk({tag, "_done"}, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, sticky_to));
        @(negedge clk); clear_inputs(); #1;
        chk({tag, "_idle_after"}, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, sticky_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mkv(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 2, 0, 0, 0, 0);
        tv[1] = mkv(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        tv[2] = mkv(0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[3] = mkv(0, 0, 0, 5, 0, 5, 5, 1, 1, 0, 0, 0, 2, 0, 0, 0);
        tv[4] = mkv(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        tv[5] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tv[6] = mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
        tv[7] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tv[8] = mkv(0, 0, 3, 3, 0, 3, 3, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        tv[9] = mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);

        clear_inputs();
        sticky_to = 0;
        rst = 1;
        rw_m = 1; rd_m = 5; rs1_e = 5; pcs = 1; mce = 1;
        @(negedge clk); #1;
        chk("reset_outputs", 12'd0);
        @(negedge clk); #1;
        chk("reset_hold", 12'd0);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear_inputs();
            rs1_d = tv[i].rs1d; rs2_d = tv[i].rs2d; rs1_e = tv[i].rs1e; rs2_e = tv[i].rs2e;
            rd_e = tv[i].rde; rd_m = tv[i].rdm; rd_w = tv[i].rdw;
            rw_m = tv[i].rwm; rw_w = tv[i].rww; rsrc = tv[i].rs; pcs = tv[i].pc;
            #1;
            chk($sformatf("vec%0d", i),
                pk(tv[i].xfa, tv[i].xfb, tv[i].xsf, tv[i].xsf, 0, tv[i].xfd, tv[i].xfe, 0, 0, 0));
        end

        for (int i = 0; i < 200; i++) begin
            logic lu, br;
            @(negedge clk);
            clear_inputs();
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rd_w = 5'($urandom_range(0, 3));
            rw_m = 1'($urandom); rw_w = 1'($urandom); rsrc = 2'($urandom);
            pcs = ($urandom_range(0, 3) == 0); mcd = 1'($urandom);
            #1;
            lu = (rsrc == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
            br = pcs;
            chk($sformatf("rnd%0d", i),
                pk(fwd_ref(rs1_e, rw_m, rd_m, rw_w, rd_w), fwd_ref(rs2_e, rw_m, rd_m, rw_w, rd_w),
                   lu && !br, lu && !br, 0, br, br || lu, 0, 0, 0));
        end

        run_mc(5, "mc_d5");
        run_mc(100, "mc_timeout");
        run_mc(1, "mc_after_to");
        run_mc(TO - 1, "mc_both");

        // Synchronous reset clears the sticky flag and aborts a pending launch.
        @(negedge clk); clear_inputs(); rst = 1; #1;
        chk("rst_clear", 12'd0);
        sticky_to = 0;
        @(negedge clk); rst = 0; #1;
        chk("rst_released", 12'd0);

        // Abort mid-BUSY: no DONE cycle, then a clean relaunch.
        @(negedge clk); clear_inputs(); mce = 1; #1;
        chk("abort_launch", pk(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("abort_busy%0d", k), pk(0, 0, 1, 1, 1, 0, 0, 1, k == 0, 0));
        end
        @(negedge clk); rst = 1; #1;
        chk("abort_rst", 12'd0);
        @(negedge clk); rst = 0; mce = 0; #1;
        chk("abort_idle", 12'd0);
        @(negedge clk); #1;
        chk("abort_no_done", 12'd0);

        for (int r = 0; r < 6; r++) begin
            run_mc(int'($urandom_range(0, 10)), $sformatf("mc_rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
